uart_loader: RTL and testbench

Boot-time program loader sitting between `uart_rx`/`uart_tx` and the core's instruction memory. After reset it announces readiness over UART, receives a little-endian word count and that many 32-bit instruction words from the host, and writes them into instruction memory from address 0. It raises `done` when the image is complete, which releases the core from its hold. It is the stage directly upstream of the core's fetch path.

---
 rtl/uart_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loader.sv
// Boot loader: sends READY_BYTE, receives a LE word count plus words, writes imem from addr 0.
// Optional checksum echo of all data bytes when LOADER_CHECKSUM_EN is defined.
module uart_loader #(
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] READY_BYTE = 8'hAA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_ferr,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  done,
  output logic                  err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_SEND_RDY, S_WAIT_TX, S_LEN, S_DATA, S_CKSUM, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN = S_CKSUM;
  logic [7:0] r_sum;
  logic       r_after_ck;
`else
  typedef enum logic [2:0] {S_SEND_RDY, S_WAIT_TX, S_LEN, S_DATA, S_DONE, S_ERR} state_t;
  localparam state_t S_FIN = S_DONE;
`endif

  // Count may equal capacity, so compare one bit wider than the address.
  localparam logic [32:0] CAP = 33'd1 << ADDR_WIDTH;

  state_t                r_state;
  logic [7:0]            r_tx_data;
  logic                  r_tx_start;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic                  r_done;
  logic                  r_err;
  logic                  r_skip;
  logic [1:0]            r_byte_cnt;
  logic [ADDR_WIDTH:0]   r_word_cnt;
  logic [31:0]           r_count;
  logic [23:0]           r_word;

  logic                  w_rx_ok;
  logic                  w_rx_bad;
  logic [31:0]           w_count_nxt;
  logic [ADDR_WIDTH:0]   w_wcnt_inc;

  assign w_rx_ok     = rx_valid & ~rx_ferr;
  assign w_rx_bad    = rx_valid & rx_ferr;
  assign w_count_nxt = {rx_data, r_count[31:8]};
  assign w_wcnt_inc  = r_word_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_SEND_RDY;
      r_tx_data    <= '0;
      r_tx_start   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_skip       <= 1'b0;
      r_byte_cnt   <= '0;
      r_word_cnt   <= '0;
      r_count      <= '0;
      r_word       <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= '0;
      r_after_ck   <= 1'b0;
`endif
    end else begin
      r_tx_start <= 1'b0;
      r_imem_we  <= 1'b0;
      if (r_imem_we) r_imem_addr <= r_imem_addr + 1'b1;
      case (r_state)
        S_SEND_RDY: if (!tx_busy) begin
          r_tx_start <= 1'b1;
          r_tx_data  <= READY_BYTE;
          r_skip     <= 1'b1;
          r_state    <= S_WAIT_TX;
        end
        // tx_busy lags tx_start by a cycle, so the first cycle is not trusted.
        S_WAIT_TX: if (r_skip) begin
          r_skip <= 1'b0;
        end else if (!tx_busy) begin
`ifdef LOADER_CHECKSUM_EN
          if (r_after_ck) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_LEN;
          end
`else
          r_state <= S_LEN;
`endif
        end
        S_LEN: if (w_rx_bad) begin
          r_err   <= 1'b1;
          r_state <= S_ERR;
        end else if (w_rx_ok) begin
          r_count    <= w_count_nxt;
          r_byte_cnt <= r_byte_cnt + 1'b1;
          if (r_byte_cnt == 2'd3) begin
            r_word_cnt <= '0;
            if ({1'b0, w_count_nxt} > CAP) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else if (w_count_nxt == 32'd0) begin
              r_state <= S_FIN;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: if (w_rx_bad) begin
          r_err   <= 1'b1;
          r_state <= S_ERR;
        end else if (w_rx_ok) begin
          r_byte_cnt <= r_byte_cnt + 1'b1;
          r_word     <= {rx_data, r_word[23:8]};
`ifdef LOADER_CHECKSUM_EN
          r_sum      <= r_sum + rx_data;
`endif
          if (r_byte_cnt == 2'd3) begin
            r_imem_we    <= 1'b1;
            r_imem_wdata <= {rx_data, r_word};
            r_word_cnt   <= w_wcnt_inc;
            if (w_wcnt_inc == r_count[ADDR_WIDTH:0]) r_state <= S_FIN;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CKSUM: if (!tx_busy) begin
          r_tx_start <= 1'b1;
          r_tx_data  <= r_sum;
          r_skip     <= 1'b1;
          r_after_ck <= 1'b1;
          r_state    <= S_WAIT_TX;
        end
`endif
        S_DONE:  r_done <= 1'b1;
        S_ERR:   r_err  <= 1'b1;
        default: r_state <= S_ERR;
      endcase
    end
  end

  assign tx_data    = r_tx_data;
  assign tx_start   = r_tx_start;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: ready byte, loads, empty/oversize/capacity counts, errors, reset.
module tb_uart_loader;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ferr = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_pass = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [7:0]    tx_q[$];

  uart_loader #(.ADDR_WIDTH(AW), .READY_BYTE(8'hAA)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (tx_start) tx_q.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] wd_at(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] wa_at(input int i);
    return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] tx_at(input int i);
    return (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hxxxx_xxxx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic f);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; rx_ferr = f;
    @(negedge clk);
    rx_valid = 1'b0; rx_ferr = 1'b0;
  endtask

  task automatic send_word_bb(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      rx_data = w[8*b +: 8]; rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    wa_q.delete(); wd_q.delete(); tx_q.delete();
    rst = 1'b0;
    tick(4);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    chk(tag, done, 1'b1);
  endtask

  initial begin
    // Reset values
    tick(3);
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_addr", imem_addr, '0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);

    // Ready byte in the first cycle after reset release
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_start", tx_start, 1'b1);
    chk("rdy_data", tx_data, 8'hAA);
    @(negedge clk);
    chk("rdy_pulse_end", tx_start, 1'b0);
    tick(6);
    chk("rdy_single", tx_q.size(), 1);

    // Two-word load with exact write timing
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("w0_we", imem_we, 1'b1);
    chk("w0_addr", imem_addr, 0);
    chk("w0_data", imem_wdata, 32'h0000_0013);
    @(negedge clk);
    chk("w0_we_drop", imem_we, 1'b0);
    chk("w0_addr_inc", imem_addr, 1);
    send_word_bb(32'hDEAD_BEEF);
    chk("w1_we", imem_we, 1'b1);
    chk("w1_addr", imem_addr, 1);
    chk("w1_data", imem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
    chk("two_done_early", done, 1'b0);
    wait_done("two_done");
    chk("two_tx_cnt", tx_q.size(), 2);
    chk("two_cksum", tx_at(1), 8'h4B);
`else
    chk("two_done", done, 1'b1);
    chk("two_tx_cnt", tx_q.size(), 1);
`endif
    chk("two_err", err, 1'b0);
    chk("two_wr_cnt", wd_q.size(), 2);
    chk("two_log0", wd_at(0), 32'h0000_0013);
    chk("two_log1a", wa_at(1), 1);
    send_byte(8'h55, 0); send_byte(8'h55, 0); send_byte(8'h55, 0); send_byte(8'h55, 0);
    tick(2);
    chk("done_sticky", done, 1'b1);
    chk("done_no_wr", wd_q.size(), 2);

    // Empty image
    restart();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_done("empty_done");
    tick(2);
    chk("empty_no_wr", wd_q.size(), 0);
    chk("empty_err", err, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk("empty_tx_cnt", tx_q.size(), 2);
    chk("empty_cksum", tx_at(1), 8'h00);
`else
    chk("empty_tx_cnt", tx_q.size(), 1);
`endif

    // Framing error on the 6th byte
    restart();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    chk("ferr_err_pre", err, 1'b0);
    send_byte(8'h00, 1);
    chk("ferr_err", err, 1'b1);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_word_bb(32'hDEAD_BEEF);
    tick(3);
    chk("ferr_no_wr", wd_q.size(), 0);
    chk("ferr_done", done, 1'b0);
    chk("ferr_no_tx", tx_q.size(), 1);

    // Oversize count 0x1001
    restart();
    send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    chk("over_err_pre", err, 1'b0);
    send_byte(8'h00, 0);
    chk("over_err", err, 1'b1);
    send_word_bb(32'h1234_5678);
    tick(2);
    chk("over_no_wr", wd_q.size(), 0);
    chk("over_done", done, 1'b0);

    // Count exactly at capacity (0x1000 words)
    restart();
    send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    chk("cap_err_len", err, 1'b0);
    for (int w = 0; w < (1 << AW); w++) begin
      logic [31:0] word;
      word = 32'(w) ^ 32'hA5A5_0000;
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        rx_data = word[8*b +: 8]; rx_valid = 1'b1;
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
    wait_done("cap_done");
    tick(2);
    chk("cap_err", err, 1'b0);
    chk("cap_wr_cnt", wd_q.size(), 1 << AW);
    chk("cap_first_addr", wa_at(0), 0);
    chk("cap_last_addr", wa_at((1 << AW) - 1), (1 << AW) - 1);
    chk("cap_last_data", wd_at((1 << AW) - 1), 32'hA5A5_0FFF);

    // Reset mid-load
    restart();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    @(negedge clk);
    rst = 1'b1; tx_busy = 1'b1;
    @(negedge clk);
    chk("mid_rst_txdata", tx_data, 8'h00);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, 0);
    wa_q.delete(); wd_q.delete(); tx_q.delete();
    rst = 1'b0;
    tick(3);
    chk("mid_busy_hold", tx_q.size(), 0);
    tx_busy = 1'b0;
    @(negedge clk);
    chk("mid_rdy_start", tx_start, 1'b1);
    chk("mid_rdy_data", tx_data, 8'hAA);
    tick(4);
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_word_bb(32'h4433_2211);
    chk("mid_w_addr", imem_addr, 0);
    chk("mid_w_data", imem_wdata, 32'h4433_2211);
    wait_done("mid_done");
    tick(2);
    chk("mid_wr_cnt", wd_q.size(), 1);
    chk("mid_err", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
